// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between M0 (CPU) and M1 (host/loader).
// Zero-latency grant with round-robin or fixed priority, burst lock and a starvation guard.
module dmem_arbiter #(
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int DMEM_SIZE = 256,
    parameter int PRIO_MODE = 0,
    parameter int MAX_WAIT  = 4
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    output logic          dmem_write,
    input  logic [DW-1:0] dmem_rdata,
    output logic          err,
    output logic [15:0]   conflict_cnt
);
    typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_t;

    localparam logic [3:0]  WMAX  = 4'(MAX_WAIT);
    localparam logic [AW:0] LIMIT = (AW+1)'(DMEM_SIZE);

    owner_t        owner, owner_nx;
    logic          last_gnt;  // 1 = M1 was granted most recently
    logic [3:0]    wait0, wait1;
    logic          g0, g1, s0, s1, in_range;

    always_comb begin
        s0 = m0_req && wait0 == WMAX;
        s1 = m1_req && wait1 == WMAX;
        g0 = 1'b0;
        g1 = 1'b0;
        if (s0 && s1) begin
            g0 = last_gnt;
            g1 = !last_gnt;
        end
        else if (s0) g0 = 1'b1;
        else if (s1) g1 = 1'b1;
        else if (owner == OWN_M0 && m0_req) g0 = 1'b1;
        else if (owner == OWN_M1 && m1_req) g1 = 1'b1;
        else if (m0_req && m1_req) begin
            g0 = PRIO_MODE != 0 || last_gnt;
            g1 = !g0;
        end
        else begin
            g0 = m0_req;
            g1 = m1_req;
        end
        // Outputs stay quiet for the whole time reset is asserted
        g0 = g0 && RSTN;
        g1 = g1 && RSTN;
    end

    assign m0_gnt     = g0;
    assign m1_gnt     = g1;
    assign dmem_addr  = g0 ? m0_addr : g1 ? m1_addr : '0;
    assign dmem_wdata = g0 ? m0_wdata : g1 ? m1_wdata : '0;
    assign in_range   = {1'b0, dmem_addr} < LIMIT;
    assign err        = (g0 || g1) && !in_range;
    assign dmem_write = in_range && ((g0 && m0_we) || (g1 && m1_we));
    assign m0_rdata   = (g0 && !m0_we && in_range) ? dmem_rdata : '0;
    assign m1_rdata   = (g1 && !m1_we && in_range) ? dmem_rdata : '0;
    assign owner_nx   = (g0 && m0_lock) ? OWN_M0 : (g1 && m1_lock) ? OWN_M1 : OWN_NONE;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            last_gnt     <= 1'b1;
            owner        <= OWN_NONE;
            wait0        <= '0;
            wait1        <= '0;
            conflict_cnt <= '0;
        end else begin
            last_gnt     <= g1 ? 1'b1 : g0 ? 1'b0 : last_gnt;
            owner        <= owner_nx;
            wait0        <= (g0 || !m0_req) ? '0 : (wait0 == WMAX) ? WMAX : wait0 + 4'd1;
            wait1        <= (g1 || !m1_req) ? '0 : (wait1 == WMAX) ? WMAX : wait1 + 4'd1;
            conflict_cnt <= conflict_cnt + 16'(m0_req && m1_req && conflict_cnt != 16'hFFFF);
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table plus hand sequences against a behavioural memory,
// with a second instance in fixed-priority mode for the starvation pattern.
module tb_dmem_arbiter;
    typedef struct packed {
        logic        rs;
        logic        r0, w0, l0;
        logic [15:0] a0, d0;
        logic        r1, w1, l1;
        logic [15:0] a1, d1;
        logic        g0, g1, wr, er;
        logic [15:0] rd0, rd1, cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        m0_req = 0, m0_we = 0, m0_lock = 0, m1_req = 0, m1_we = 0, m1_lock = 0;
    logic [15:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic        m0_gnt, m1_gnt, dmem_write, err;
    logic [15:0] m0_rdata, m1_rdata, dmem_addr, dmem_wdata, dmem_rdata, conflict_cnt;
    logic [15:0] mem [256];

    logic        p_req0 = 0, p_req1 = 0, p_zero = 0;
    logic [15:0] p_zero16 = 0;
    logic        p_g0, p_g1, p_write, p_err;
    logic [15:0] p_rd0, p_rd1, p_addr, p_wdata, p_cnt;

    int   checks = 0;
    int   errors = 0;
    vec_t sb [$];
    logic [1:0] pq [$];
    vec_t tbl [20];
    vec_t seq [7];
    vec_t init_rst;

    always #5 clk = ~clk;

    assign dmem_rdata = mem[dmem_addr[7:0]];
    always @(posedge clk) if (dmem_write) mem[dmem_addr[7:0]] <= dmem_wdata;

    dmem_arbiter #(.PRIO_MODE(0)) dut (
        .CLK(clk), .RSTN(rstn),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_write(dmem_write),
        .dmem_rdata(dmem_rdata), .err(err), .conflict_cnt(conflict_cnt)
    );

    dmem_arbiter #(.PRIO_MODE(1)) dut_p (
        .CLK(clk), .RSTN(rstn),
        .m0_req(p_req0), .m0_we(p_zero), .m0_lock(p_zero), .m0_addr(p_zero16), .m0_wdata(p_zero16),
        .m0_gnt(p_g0), .m0_rdata(p_rd0),
        .m1_req(p_req1), .m1_we(p_zero), .m1_lock(p_zero), .m1_addr(p_zero16), .m1_wdata(p_zero16),
        .m1_gnt(p_g1), .m1_rdata(p_rd1),
        .dmem_addr(p_addr), .dmem_wdata(p_wdata), .dmem_write(p_write),
        .dmem_rdata(p_zero16), .err(p_err), .conflict_cnt(p_cnt)
    );

    function automatic vec_t v(input logic rs, r0, w0, l0, input logic [15:0] a0, d0,
                               input logic r1, w1, l1, input logic [15:0] a1, d1,
                               input logic g0, g1, wr, er, input logic [15:0] rd0, rd1, cnt);
        return '{rs, r0, w0, l0, a0, d0, r1, w1, l1, a1, d1, g0, g1, wr, er, rd0, rd1, cnt};
    endfunction

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic apply(input vec_t x, input string tag);
        vec_t e;
        @(posedge clk);
        #1;
        rstn = x.rs;
        m0_req = x.r0; m0_we = x.w0; m0_lock = x.l0; m0_addr = x.a0; m0_wdata = x.d0;
        m1_req = x.r1; m1_we = x.w1; m1_lock = x.l1; m1_addr = x.a1; m1_wdata = x.d1;
        sb.push_back(x);
        @(negedge clk);
        e = sb.pop_front();
        chk({tag, ".m0_gnt"}, 16'(m0_gnt), 16'(e.g0));
        chk({tag, ".m1_gnt"}, 16'(m1_gnt), 16'(e.g1));
        chk({tag, ".dmem_write"}, 16'(dmem_write), 16'(e.wr));
        chk({tag, ".err"}, 16'(err), 16'(e.er));
        chk({tag, ".m0_rdata"}, m0_rdata, e.rd0);
        chk({tag, ".m1_rdata"}, m1_rdata, e.rd1);
        chk({tag, ".conflict_cnt"}, conflict_cnt, e.cnt);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
        init_rst = v(0, 1,1,0,5,'h1111, 1,0,0,6,0, 0,0,0,0, 0,0,0);
        // round-robin ties, single accesses, out-of-range, M1 locked burst with starvation preempt
        tbl[0]  = v(1, 1,0,0,1,0,       1,0,0,2,0,        1,0,0,0, 'hA001,0,0);
        tbl[1]  = v(1, 1,0,0,3,0,       1,0,0,4,0,        0,1,0,0, 0,'hA004,1);
        tbl[2]  = v(1, 1,0,0,5,0,       1,0,0,6,0,        1,0,0,0, 'hA005,0,2);
        tbl[3]  = v(1, 1,0,0,7,0,       1,0,0,8,0,        0,1,0,0, 0,'hA008,3);
        tbl[4]  = v(1, 1,0,0,9,0,       1,0,0,10,0,       1,0,0,0, 'hA009,0,4);
        tbl[5]  = v(1, 1,0,0,11,0,      1,0,0,12,0,       0,1,0,0, 0,'hA00C,5);
        tbl[6]  = v(1, 0,0,0,0,0,       0,0,0,0,0,        0,0,0,0, 0,0,6);
        tbl[7]  = v(1, 0,0,0,0,0,       1,1,0,20,'h1234,  0,1,1,0, 0,0,6);
        tbl[8]  = v(1, 1,0,0,20,0,      0,0,0,0,0,        1,0,0,0, 'h1234,0,6);
        tbl[9]  = v(1, 1,1,0,'h100,'hBEEF, 0,0,0,0,0,     1,0,0,1, 0,0,6);
        tbl[10] = v(1, 1,0,0,'h100,0,   0,0,0,0,0,        1,0,0,1, 0,0,6);
        tbl[11] = v(1, 1,0,0,30,0,      1,1,1,10,'hB010,  0,1,1,0, 0,0,6);
        tbl[12] = v(1, 1,0,0,30,0,      1,1,1,11,'hB011,  0,1,1,0, 0,0,7);
        tbl[13] = v(1, 1,0,0,30,0,      1,1,1,12,'hB012,  0,1,1,0, 0,0,8);
        tbl[14] = v(1, 1,0,0,30,0,      1,1,1,13,'hB013,  0,1,1,0, 0,0,9);
        tbl[15] = v(1, 1,0,0,30,0,      1,1,1,14,'hB014,  1,0,0,0, 'hA01E,0,10);
        tbl[16] = v(1, 0,0,0,0,0,       1,1,0,14,'hB014,  0,1,1,0, 0,0,11);
        tbl[17] = v(1, 1,0,0,10,0,      0,0,0,0,0,        1,0,0,0, 'hB010,0,11);
        tbl[18] = v(1, 1,0,0,13,0,      0,0,0,0,0,        1,0,0,0, 'hB013,0,11);
        tbl[19] = v(1, 0,0,0,0,0,       1,0,0,14,0,       0,1,0,0, 0,'hB014,11);
        // M0 lock with M1 waiting to 3, reset mid-lock with a pending write, then fresh arbitration
        seq[0]  = v(1, 1,0,1,40,0,      1,0,0,41,0,       1,0,0,0, 'hA028,0,11);
        seq[1]  = v(1, 1,0,1,40,0,      1,0,0,41,0,       1,0,0,0, 'hA028,0,12);
        seq[2]  = v(1, 1,0,1,40,0,      1,0,0,41,0,       1,0,0,0, 'hA028,0,13);
        seq[3]  = v(0, 1,1,1,50,'hDEAD, 1,0,0,41,0,       0,0,0,0, 0,0,0);
        seq[4]  = v(0, 1,1,1,50,'hDEAD, 1,0,0,41,0,       0,0,0,0, 0,0,0);
        seq[5]  = v(1, 1,0,0,50,0,      1,0,0,41,0,       1,0,0,0, 'hA032,0,0);
        seq[6]  = v(1, 1,0,0,50,0,      1,0,0,41,0,       0,1,0,0, 0,'hA029,1);

        apply(init_rst, "reset0");
        apply(init_rst, "reset1");
        for (int i = 0; i < 20; i++) apply(tbl[i], $sformatf("tbl%0d", i));
        for (int i = 0; i < 7; i++) apply(seq[i], $sformatf("midlock%0d", i));

        @(posedge clk);
        #1;
        m0_req = 0;
        m1_req = 0;
        for (int i = 0; i < 10; i++) begin
            logic [1:0] e;
            @(posedge clk);
            #1;
            p_req0 = 1;
            p_req1 = 1;
            pq.push_back({i % 5 != 4, i % 5 == 4});
            @(negedge clk);
            e = pq.pop_front();
            chk($sformatf("prio%0d.m0_gnt", i), 16'(p_g0), 16'(e[1]));
            chk($sformatf("prio%0d.m1_gnt", i), 16'(p_g1), 16'(e[0]));
        end
        if (sb.size() != 0 || pq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size() + pq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
